// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package hazard_ctrl_pkg;

  localparam int REG_W_DEF = 5;
  localparam int CNT_W_DEF = 32;

  typedef logic [REG_W_DEF-1:0] regbits_t;

  typedef logic [1:0] hazard_state_t;
  localparam hazard_state_t RUN    = 2'd0;
  localparam hazard_state_t DRAIN  = 2'd1;
  localparam hazard_state_t HALTED = 2'd2;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard inputs from the datapath and pipeline-register controls back to it.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             ihit;
  logic             dhit;
  logic             ex_mem_read;
  regbits_t         ex_wsel;
  regbits_t         de_rsel1;
  regbits_t         de_rsel2;
  logic             de_use1;
  logic             de_use2;
  logic             redirect;
  logic             mem_dreq;
  logic             mem_halt;

  logic             pc_en;
  logic             ifde_en;
  logic             ifde_flush;
  logic             deex_en;
  logic             deex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             memwb_en;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  ihit, dhit, ex_mem_read, ex_wsel, de_rsel1, de_rsel2,
           de_use1, de_use2, redirect, mem_dreq, mem_halt,
    output pc_en, ifde_en, ifde_flush, deex_en, deex_flush,
           exmem_en, exmem_flush, memwb_en, halt, stall_cnt, flush_cnt
  );

  modport master (
    output ihit, dhit, ex_mem_read, ex_wsel, de_rsel1, de_rsel2,
           de_use1, de_use2, redirect, mem_dreq, mem_halt,
    input  pc_en, ifde_en, ifde_flush, deex_en, deex_flush,
           exmem_en, exmem_flush, memwb_en, halt, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module hazard_ctrl_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (inc && (count_q != '1))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush arbitration for the 5-stage pipeline, halt-drain FSM and perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int REG_W = REG_W_DEF
) (
  input  logic       CLK,
  input  logic       nRST,
  hazard_ctrl_if.slave hif
);

  hazard_state_t    state_q, state_d;
  logic             halt_q, halt_d;
  logic             memwait, loaduse;
  logic             stall_inc, flush_inc;
  logic             pc_en, ifde_en, ifde_flush, deex_en, deex_flush;
  logic             exmem_en, exmem_flush, memwb_en;
  logic [REG_W-1:0] wsel, rs1, rs2;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  assign wsel = hif.ex_wsel;
  assign rs1  = hif.de_rsel1;
  assign rs2  = hif.de_rsel2;

  always_comb begin
    memwait = hif.mem_dreq & ~hif.dhit;
    // x0 is never a real producer, so it cannot create a load-use dependency.
    loaduse = hif.ex_mem_read & (wsel != '0) &
              ((hif.de_use1 & (rs1 == wsel)) | (hif.de_use2 & (rs2 == wsel)));

    pc_en       = 1'b0;
    ifde_en     = 1'b0;
    ifde_flush  = 1'b0;
    deex_en     = 1'b0;
    deex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    state_d     = state_q;
    halt_d      = halt_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    case (state_q)
      RUN: begin
        if (!memwait) begin
          // Redirect outranks younger hazards: they sit on the wrong path.
          if (hif.redirect) begin
            pc_en      = 1'b1;
            ifde_flush = 1'b1;
            deex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else if (loaduse) begin
            deex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else if (!hif.ihit) begin
            ifde_flush = 1'b1;
            deex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else begin
            pc_en    = 1'b1;
            ifde_en  = 1'b1;
            deex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
          end
          if (hif.mem_halt)
            state_d = DRAIN;
        end
        stall_inc = ~pc_en;
        flush_inc = ~memwait & hif.redirect;
      end
      DRAIN: begin
        ifde_flush  = 1'b1;
        deex_flush  = 1'b1;
        exmem_flush = 1'b1;
        memwb_en    = 1'b1;
        state_d     = HALTED;
        halt_d      = 1'b1;
      end
      HALTED: ;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  hazard_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .inc   (stall_inc),
    .clear (1'b0),
    .count (stall_cnt)
  );

  hazard_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .inc   (flush_inc),
    .clear (1'b0),
    .count (flush_cnt)
  );

  assign hif.pc_en       = pc_en;
  assign hif.ifde_en     = ifde_en;
  assign hif.ifde_flush  = ifde_flush;
  assign hif.deex_en     = deex_en;
  assign hif.deex_flush  = deex_flush;
  assign hif.exmem_en    = exmem_en;
  assign hif.exmem_flush = exmem_flush;
  assign hif.memwb_en    = memwb_en;
  assign hif.halt        = halt_q;
  assign hif.stall_cnt   = stall_cnt;
  assign hif.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios plus randomized traffic for hazard_ctrl against a table-driven model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  hazard_ctrl_if #(.CNT_W(CW)) hif ();

  hazard_ctrl #(.CNT_W(CW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .hif  (hif)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef enum {M_RUN, M_DRAIN, M_HALTED} mode_e;
  mode_e m_mode;
  logic  m_halt;
  int    m_stall, m_flush;

  // Control vector bit order: pc_en ifde_en ifde_flush deex_en deex_flush exmem_en exmem_flush memwb_en
  localparam logic [7:0] V_FREEZE   = 8'b0000_0000;
  localparam logic [7:0] V_REDIRECT = 8'b1010_1101;
  localparam logic [7:0] V_LOADUSE  = 8'b0000_1101;
  localparam logic [7:0] V_IMISS    = 8'b0011_0101;
  localparam logic [7:0] V_ADVANCE  = 8'b1101_0101;
  localparam logic [7:0] V_DRAIN    = 8'b0010_1011;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ctl_dut();
    return {hif.pc_en, hif.ifde_en, hif.ifde_flush, hif.deex_en, hif.deex_flush,
            hif.exmem_en, hif.exmem_flush, hif.memwb_en};
  endfunction

  function automatic bit model_memwait();
    return (hif.mem_dreq === 1'b1) && (hif.dhit !== 1'b1);
  endfunction

  function automatic bit model_loaduse();
    regbits_t src [2];
    logic     used [2];
    bit       hit;
    src[0]  = hif.de_rsel1;  src[1]  = hif.de_rsel2;
    used[0] = hif.de_use1;   used[1] = hif.de_use2;
    hit = 1'b0;
    if (hif.ex_mem_read && hif.ex_wsel != 0)
      for (int i = 0; i < 2; i++)
        if (used[i] && src[i] == hif.ex_wsel) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [7:0] ctl_model();
    if (m_mode == M_HALTED) return V_FREEZE;
    if (m_mode == M_DRAIN)  return V_DRAIN;
    if (model_memwait())    return V_FREEZE;
    if (hif.redirect)       return V_REDIRECT;
    if (model_loaduse())    return V_LOADUSE;
    if (!hif.ihit)          return V_IMISS;
    return V_ADVANCE;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  task automatic model_reset();
    m_mode  = M_RUN;
    m_halt  = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic check_regs();
    check_val("halt", hif.halt, m_halt);
    check_val("stall_cnt", hif.stall_cnt, m_stall);
    check_val("flush_cnt", hif.flush_cnt, m_flush);
  endtask

  // One clock: check combinational controls, advance model on the edge, check registered state.
  task automatic step();
    logic [7:0] exp;
    bit         mw;
    #2;
    exp = ctl_model();
    mw  = model_memwait();
    check_val("ctl", ctl_dut(), exp);
    @(posedge CLK);
    case (m_mode)
      M_RUN: begin
        if (!exp[7]) m_stall = sat_inc(m_stall);
        if (!mw && hif.redirect) m_flush = sat_inc(m_flush);
        if (!mw && hif.mem_halt) m_mode = M_DRAIN;
      end
      M_DRAIN: begin
        m_mode = M_HALTED;
        m_halt = 1'b1;
      end
      default: ;
    endcase
    #1;
    check_regs();
  endtask

  task automatic set_idle();
    hif.ihit        = 1'b1;
    hif.dhit        = 1'b0;
    hif.ex_mem_read = 1'b0;
    hif.ex_wsel     = '0;
    hif.de_rsel1    = '0;
    hif.de_rsel2    = '0;
    hif.de_use1     = 1'b0;
    hif.de_use2     = 1'b0;
    hif.redirect    = 1'b0;
    hif.mem_dreq    = 1'b0;
    hif.mem_halt    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    model_reset();
    #1;
    check_regs();
    @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic rand_inputs();
    hif.ihit        = ($urandom_range(0, 3) != 0);
    hif.dhit        = $urandom_range(0, 1);
    hif.mem_dreq    = ($urandom_range(0, 2) == 0);
    hif.ex_mem_read = ($urandom_range(0, 4) < 2);
    hif.ex_wsel     = regbits_t'($urandom_range(0, 3));
    hif.de_rsel1    = regbits_t'($urandom_range(0, 3));
    hif.de_rsel2    = regbits_t'($urandom_range(0, 3));
    hif.de_use1     = $urandom_range(0, 1);
    hif.de_use2     = $urandom_range(0, 1);
    hif.redirect    = ($urandom_range(0, 6) == 0);
    hif.mem_halt    = ($urandom_range(0, 60) == 0);
  endtask

  initial begin
    nRST = 1'b0;
    set_idle();
    model_reset();
    do_reset();

    // Load-use on rs1 inserts one bubble, then the pipe advances again.
    hif.ex_mem_read = 1'b1; hif.ex_wsel = 5'd5; hif.de_rsel1 = 5'd5; hif.de_use1 = 1'b1;
    step();
    hif.ex_mem_read = 1'b0;
    step();
    check_val("s1_stall_cnt", hif.stall_cnt, 1);

    // x0 destination and an unused source never stall.
    hif.ex_mem_read = 1'b1; hif.ex_wsel = 5'd0; hif.de_rsel1 = 5'd0;
    step();
    hif.ex_wsel = 5'd5; hif.de_rsel1 = 5'd5; hif.de_use1 = 1'b0;
    step();
    check_val("s2_stall_cnt", hif.stall_cnt, 1);

    // Redirect wins over a coincident load-use and imem miss.
    hif.de_use1 = 1'b1; hif.ihit = 1'b0; hif.redirect = 1'b1;
    step();
    check_val("s3_flush_cnt", hif.flush_cnt, 1);
    check_val("s3_stall_cnt", hif.stall_cnt, 1);

    // Three cycles of memory wait freeze everything.
    set_idle();
    hif.mem_dreq = 1'b1;
    repeat (3) step();
    hif.dhit = 1'b1;
    step();
    check_val("s4_stall_cnt", hif.stall_cnt, 4);

    // Halt waits out the memory stall, drains for one cycle, then sticks.
    do_reset();
    set_idle();
    hif.mem_halt = 1'b1; hif.mem_dreq = 1'b1;
    repeat (2) step();
    hif.dhit = 1'b1;
    step();
    rand_inputs();
    step();
    check_val("s5_halt", hif.halt, 1);
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      step();
    end

    // Stall counter saturates at all-ones.
    do_reset();
    set_idle();
    hif.ihit = 1'b0;
    repeat (CMAX + 2) step();
    check_val("s6_stall_sat", hif.stall_cnt, CMAX);

    // Asynchronous reset in the middle of a drain.
    set_idle();
    hif.mem_halt = 1'b1;
    step();
    hif.mem_halt = 1'b0;
    #2 nRST = 1'b0;
    model_reset();
    #1;
    check_regs();
    check_val("s6_ctl_after_rst", ctl_dut(), V_ADVANCE);
    @(negedge CLK);
    nRST = 1'b1;
    step();

    // Randomized traffic with periodic resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) do_reset();
      rand_inputs();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
